// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers PC / IF-ID / ID-EX enables for a simple in-order
// pipeline. It arbitrates branch redirects, load-use stalls and instruction
// memory misses, and it flags a sticky fault when memory never answers.
module fetch_sequencer #(
    parameter int INIT_HOLD = 2,
    parameter int MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic        load_use,
    input  logic        imem_ready,
    output logic        pc_en,
    output logic        pc_src,
    output logic        old_br,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        imem_req,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] redir_cnt
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_STALL    = 3'd2,
        S_REDIRECT = 3'd3,
        S_MEMWAIT  = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    // Last count value of each counter before the FSM moves on.
    localparam logic [3:0] HOLD_LAST = 4'(INIT_HOLD - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_r;
    state_t      next_s;
    logic [3:0]  hold_r;
    logic [7:0]  wait_r;
    logic        fault_r;
    logic [15:0] stall_r;
    logic [15:0] redir_r;

    logic        redir_s;
    logic        wait_clr_s;
    logic        wait_inc_s;
    logic        stall_inc_s;

    // Next-state and control decode; outputs follow state and inputs directly.
    always_comb begin
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        old_br      = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        imem_req    = 1'b1;
        next_s      = state_r;
        redir_s     = 1'b0;
        wait_clr_s  = 1'b0;
        wait_inc_s  = 1'b0;
        if (reset) begin
            imem_req    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            next_s      = S_INIT;
        end else begin
            case (state_r)
                S_INIT: begin
                    imem_req    = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (hold_r == HOLD_LAST) begin
                        next_s = S_RUN;
                    end else begin
                        next_s = S_INIT;
                    end
                end
                S_RUN, S_STALL, S_MEMWAIT, S_REDIRECT: begin
                    // The squashed slot after a redirect ignores decode hazards.
                    if (br_taken && (state_r != S_REDIRECT)) begin
                        pc_en      = 1'b1;
                        pc_src     = 1'b1;
                        old_br     = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        redir_s    = 1'b1;
                        next_s     = S_REDIRECT;
                    end else if (load_use && (state_r != S_REDIRECT)) begin
                        idex_bubble = 1'b1;
                        next_s      = S_STALL;
                    end else if (!imem_ready) begin
                        idex_bubble = 1'b1;
                        if (state_r == S_MEMWAIT) begin
                            wait_inc_s = 1'b1;
                            if (wait_r == WAIT_LAST) begin
                                next_s = S_ERROR;
                            end else begin
                                next_s = S_MEMWAIT;
                            end
                        end else begin
                            wait_clr_s = 1'b1;
                            next_s     = S_MEMWAIT;
                        end
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        if (state_r == S_REDIRECT) begin
                            idex_bubble = 1'b1;
                        end else begin
                            idex_bubble = 1'b0;
                        end
                        next_s = S_RUN;
                    end
                end
                S_ERROR: begin
                    imem_req    = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    next_s      = S_ERROR;
                end
                default: begin
                    imem_req    = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    next_s      = S_INIT;
                end
            endcase
        end
    end

    // A lost cycle is any pipeline-active state in which the PC does not advance.
    always_comb begin
        if (!reset && !pc_en &&
            ((state_r == S_RUN) || (state_r == S_STALL) ||
             (state_r == S_REDIRECT) || (state_r == S_MEMWAIT))) begin
            stall_inc_s = 1'b1;
        end else begin
            stall_inc_s = 1'b0;
        end
    end

    // State register, INIT hold timer, memory wait timer, statistics and fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_INIT;
            hold_r  <= 4'd0;
            wait_r  <= 8'd0;
            stall_r <= 16'd0;
            redir_r <= 16'd0;
            fault_r <= 1'b0;
        end else begin
            state_r <= next_s;
            if ((state_r == S_INIT) && (hold_r != HOLD_LAST)) begin
                hold_r <= hold_r + 4'd1;
            end
            if (wait_clr_s) begin
                wait_r <= 8'd0;
            end else if (wait_inc_s) begin
                wait_r <= wait_r + 8'd1;
            end
            if (stall_inc_s && (stall_r != CNT_MAX)) begin
                stall_r <= stall_r + 16'd1;
            end
            if (redir_s && (redir_r != CNT_MAX)) begin
                redir_r <= redir_r + 16'd1;
            end
            if (next_s == S_ERROR) begin
                fault_r <= 1'b1;
            end
        end
    end

    // While reset is held the visible status looks like INIT.
    assign state     = reset ? 3'd0 : state_r;
    assign fault     = fault_r & ~reset;
    assign stall_cnt = stall_r;
    assign redir_cnt = redir_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each scenario task queues expected
// output vectors as it drives stimulus and compares them when sampled.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_taken = 1'b0;
    logic        load_use = 1'b0;
    logic        imem_ready = 1'b1;
    logic        pc_en, pc_src, old_br, ifid_en, ifid_flush, idex_bubble, imem_req, fault;
    logic [2:0]  state;
    logic [15:0] stall_cnt, redir_cnt;

    int errors = 0;
    int checks = 0;

    // Control patterns: {pc_en, pc_src, old_br, ifid_en, ifid_flush, idex_bubble, imem_req}
    localparam logic [6:0] C_INIT  = 7'b0000110;
    localparam logic [6:0] C_GO    = 7'b1001001;
    localparam logic [6:0] C_REDIR = 7'b1111101;
    localparam logic [6:0] C_BUB   = 7'b0000011;
    localparam logic [6:0] C_RDGO  = 7'b1001011;
    localparam logic [6:0] C_ERR   = 7'b0000110;

    typedef struct packed {
        logic        rst;
        logic        br;
        logic        lu;
        logic        rdy;
        logic [10:0] exp;
    } step_t;

    logic [10:0] sb[$];

    fetch_sequencer #(.INIT_HOLD(2), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .br_taken(br_taken), .load_use(load_use),
        .imem_ready(imem_ready), .pc_en(pc_en), .pc_src(pc_src), .old_br(old_br),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .imem_req(imem_req), .fault(fault), .state(state),
        .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic [2:0] st, input logic [6:0] c, input logic f);
        return {st, c, f};
    endfunction

    function automatic step_t stp(input logic r, input logic b, input logic l,
                                  input logic y, input logic [10:0] e);
        step_t s;
        s.rst = r; s.br = b; s.lu = l; s.rdy = y; s.exp = e;
        return s;
    endfunction

    function automatic logic [10:0] obs();
        return {state, pc_en, pc_src, old_br, ifid_en, ifid_flush, idex_bubble, imem_req, fault};
    endfunction

    // Drive one cycle of stimulus after the edge, queue its expectation, wait for the sample point.
    task automatic drive_step(input step_t s);
        @(posedge clk);
        #1;
        reset      = s.rst;
        br_taken   = s.br;
        load_use   = s.lu;
        imem_ready = s.rdy;
        sb.push_back(s.exp);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step_t t[$];
        logic [10:0] e;
        for (int k = 0; k < 2; k++) t.push_back(stp(1'b1, 1'b0, 1'b0, 1'b1, mk(3'd0, C_INIT, 1'b0)));
        for (int k = 0; k < 2; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd0, C_INIT, 1'b0)));
        for (int k = 0; k < 4; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if ({stall_cnt, redir_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d want 0/0", stall_cnt, redir_cnt);
        end
    endtask

    task automatic test_branch();
        step_t t[$];
        logic [10:0] e;
        t.push_back(stp(1'b0, 1'b1, 1'b0, 1'b1, mk(3'd1, C_REDIR, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd3, C_RDGO, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL branch step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if (redir_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL branch counters: got redir=%0d stall=%0d want 1/0", redir_cnt, stall_cnt);
        end
    endtask

    task automatic test_stall();
        step_t t[$];
        logic [10:0] e;
        t.push_back(stp(1'b0, 1'b0, 1'b1, 1'b1, mk(3'd1, C_BUB, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b1, 1'b1, mk(3'd2, C_BUB, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd2, C_GO, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL stall step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall count: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_priority();
        step_t t[$];
        logic [10:0] e;
        t.push_back(stp(1'b0, 1'b1, 1'b1, 1'b1, mk(3'd1, C_REDIR, 1'b0)));
        t.push_back(stp(1'b0, 1'b1, 1'b1, 1'b1, mk(3'd3, C_RDGO, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL priority step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if (redir_cnt !== 16'd2 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL priority counters: got redir=%0d stall=%0d want 2/2", redir_cnt, stall_cnt);
        end
    endtask

    task automatic test_memwait_branch();
        step_t t[$];
        logic [10:0] e;
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd1, C_BUB, 1'b0)));
        for (int k = 0; k < 2; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, C_BUB, 1'b0)));
        t.push_back(stp(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd4, C_REDIR, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd3, C_RDGO, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        // A fresh miss run of 14 waits must not fault: the earlier wait count is gone.
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd1, C_BUB, 1'b0)));
        for (int k = 0; k < 14; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, C_BUB, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd4, C_GO, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL memwait_branch step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if (redir_cnt !== 16'd3 || stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL memwait_branch counters: got redir=%0d stall=%0d want 3/20", redir_cnt, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        step_t t[$];
        logic [10:0] e;
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd1, C_BUB, 1'b0)));
        for (int k = 0; k < 15; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, C_BUB, 1'b0)));
        for (int k = 0; k < 3; k++) t.push_back(stp(1'b0, 1'b1, 1'b1, 1'b1, mk(3'd5, C_ERR, 1'b1)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd5, C_ERR, 1'b1)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cnt !== 16'd36) begin
            errors++;
            $display("FAIL timeout stall count: got %0d want 36", stall_cnt);
        end
        // Reset recovers from ERROR and clears the fault and statistics.
        t.delete();
        t.push_back(stp(1'b1, 1'b0, 1'b0, 1'b1, mk(3'd0, C_INIT, 1'b0)));
        for (int k = 0; k < 2; k++) t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd0, C_INIT, 1'b0)));
        t.push_back(stp(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd1, C_GO, 1'b0)));
        foreach (t[i]) begin
            drive_step(t[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL recover step %0d: got %b want %b", i, obs(), e);
            end
        end
        checks++;
        if ({stall_cnt, redir_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL recover counters: got %0d/%0d want 0/0", stall_cnt, redir_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_priority();
        test_memwait_branch();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
